// File: rtl/bitty_sequencer.sv
// bitty_sequencer: program counter and fetch/issue sequencer for the bitty
// control unit. Fetches one 16-bit instruction at a time from a synchronous
// memory, pulses the three control-unit stage enables in order, then waits
// (under a watchdog) for the control unit to report completion.
module bitty_sequencer #(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] end_addr,
    input  logic              stall,
    output logic              imem_rd,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [15:0]       imem_data,
    output logic [15:0]       instruction,
    output logic              en_i,
    output logic              en_s,
    output logic              en_c,
    input  logic              cu_done,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              finished,
    output logic              error,
    output logic [15:0]       instr_count
);

    // Watchdog wide enough to hold TIMEOUT itself.
    localparam int WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT_MEM,
        S_ISSUE,
        S_LOAD_EN,
        S_CALC_EN,
        S_WAIT_DONE,
        S_FAULT
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] end_q, end_d;
    logic [15:0]       instr_q, instr_d;
    logic [15:0]       count_q, count_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic              error_q, error_d;
    logic              finished_q, finished_d;

    // Completed-instruction counter sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Next-state, datapath updates and per-state strobes.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        end_d      = end_q;
        instr_d    = instr_q;
        count_d    = count_q;
        wd_d       = wd_q;
        error_d    = error_q;
        finished_d = 1'b0;
        imem_rd    = 1'b0;
        en_i       = 1'b0;
        en_s       = 1'b0;
        en_c       = 1'b0;

        case (state_q)
            S_IDLE, S_FAULT: begin
                // A new program may be launched from either resting state.
                if (start) begin
                    pc_d    = start_addr;
                    end_d   = end_addr;
                    count_d = 16'd0;
                    error_d = 1'b0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                imem_rd = 1'b1;
                state_d = S_WAIT_MEM;
            end
            S_WAIT_MEM: begin
                instr_d = imem_data;
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (!stall) begin
                    en_i    = 1'b1;
                    state_d = S_LOAD_EN;
                end
            end
            S_LOAD_EN: begin
                if (!stall) begin
                    en_s    = 1'b1;
                    state_d = S_CALC_EN;
                end
            end
            S_CALC_EN: begin
                if (!stall) begin
                    en_c    = 1'b1;
                    wd_d    = '0;
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                wd_d = wd_q + 1'b1;
                if (cu_done) begin
                    count_d = sat_inc16(count_q);
                    if (pc_q == end_q) begin
                        finished_d = 1'b1;
                        state_d    = S_IDLE;
                    end else begin
                        pc_d    = pc_q + 1'b1;
                        state_d = S_FETCH;
                    end
                end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
                    // Last allowed cycle passed without a done: give up.
                    error_d = 1'b1;
                    state_d = S_FAULT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset returns every output to zero at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            pc_q       <= '0;
            end_q      <= '0;
            instr_q    <= 16'd0;
            count_q    <= 16'd0;
            wd_q       <= '0;
            error_q    <= 1'b0;
            finished_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            end_q      <= end_d;
            instr_q    <= instr_d;
            count_q    <= count_d;
            wd_q       <= wd_d;
            error_q    <= error_d;
            finished_q <= finished_d;
        end
    end

    assign pc          = pc_q;
    assign imem_addr   = pc_q;
    assign instruction = instr_q;
    assign instr_count = count_q;
    assign error       = error_q;
    assign finished    = finished_q;
    assign busy        = (state_q != S_IDLE) && (state_q != S_FAULT);

endmodule

// File: doc/bitty_sequencer.md
# bitty_sequencer

Instruction sequencer for the bitty processor. It owns the program counter, fetches 16-bit instructions from a synchronous-read instruction memory and drives the control unit's `instruction`, `en_i`, `en_s` and `en_c` inputs in the required order. It then waits for the control unit's `done` before advancing. It sits between the instruction memory and the control unit, and runs a program from `start_addr` to `end_addr` inclusive on a `start` pulse.

## Interface

Parameters:

- `ADDR_W`, default 8: instruction-memory address width.
- `TIMEOUT`, default 15: maximum number of cycles spent in WAIT_DONE before a fault is declared.

Ports:

- `clk`  in  1: clock; all state changes on the rising edge.
- `reset`  in  1: asynchronous, active-high.
- `start`  in  1: single-cycle request to run a program. Honoured only in IDLE or FAULT.
- `start_addr`  in  ADDR_W: first instruction address, sampled with `start`.
- `end_addr`  in  ADDR_W: last instruction address (inclusive), sampled with `start`.
- `stall`  in  1: holds the sequencer in ISSUE, LOAD_EN or CALC_EN with the enables low.
- `imem_rd`  out  1: memory read strobe. Data is valid on `imem_data` one cycle later.
- `imem_addr`  out  ADDR_W: equal to `pc`.
- `imem_data`  in  16: memory read data.
- `instruction`  out  16: latched instruction to the control unit.
- `en_i`, `en_s`, `en_c`  out  1 each: control-unit stage enables, each a one-cycle pulse.
- `cu_done`  in  1: control unit `done` (one-cycle pulse).
- `pc`  out  ADDR_W: current instruction address.
- `busy`  out  1: high in every state except IDLE and FAULT.
- `finished`  out  1: one-cycle pulse when the program completes.
- `error`  out  1: sticky watchdog fault flag.
- `instr_count`  out  16: instructions completed since the last accepted `start`.

## Operation

- States are IDLE, FETCH, WAIT_MEM, ISSUE, LOAD_EN, CALC_EN, WAIT_DONE and FAULT.
- IDLE:
  - On `start`, the sequencer sets `pc <= start_addr`, latches `end_addr`, clears `instr_count` and `error`, and moves to FETCH.
- FETCH:
  - `imem_rd=1`, with `imem_addr=pc`.
  - Moves to WAIT_MEM.
- WAIT_MEM:
  - `instruction <= imem_data`.
  - Moves to ISSUE.
- ISSUE:
  - `en_i=1` if `stall=0`, then moves to LOAD_EN.
  - Otherwise holds with `en_i=0`.
- LOAD_EN:
  - Same rule as ISSUE, using `en_s`; moves to CALC_EN.
- CALC_EN:
  - Same rule as ISSUE, using `en_c`; moves to WAIT_DONE.
- WAIT_DONE:
  - A watchdog counter starts at 0 on entry and increments each cycle.
  - On `cu_done`:
    - `instr_count` increments, saturating at 0xFFFF.
    - If `pc == end_addr`: move to IDLE and pulse `finished` in the next cycle.
    - Otherwise: `pc <= pc + 1` (mod 2^ADDR_W) and move to FETCH.
  - If the counter reaches TIMEOUT without `cu_done`, set `error=1` and move to FAULT.
- FAULT:
  - All enables are low and `error` stays high.
  - `start` behaves as in IDLE (it clears `error`).
- `stall` has no effect in FETCH, WAIT_MEM or WAIT_DONE.
- `start` while `busy` is ignored; no sampled values change.
- Wrap-around: when `start_addr > end_addr`, `pc` wraps past all-ones to 0 and continues until it equals `end_addr`.
- `instruction` holds its value between fetches and after completion.
- `cu_done` seen outside WAIT_DONE is ignored.

## Timing

- Reset values: state IDLE; `pc`, `imem_addr`, `instruction` and `instr_count` are 0. `imem_rd`, `en_i`, `en_s`, `en_c`, `busy`, `finished` and `error` are all 0.
- `start` is sampled at cycle 0; the sequencer is in FETCH at cycle 1.
- With no stall, the per-instruction timeline, with F the FETCH cycle, is:
  - F: FETCH.
  - F+1: WAIT_MEM.
  - F+2: ISSUE (`en_i`).
  - F+3: LOAD_EN (`en_s`).
  - F+4: CALC_EN (`en_c`).
  - F+5 and F+6: WAIT_DONE; the control unit raises `done` at F+6.
  - Next FETCH is at F+7, giving 7 cycles per instruction.
- For N instructions with no stall, `finished` is high in cycle 7N+1 after the `start` cycle.
- Each stalled cycle adds exactly one cycle of latency.
- The enables are never high simultaneously and each is high for exactly one cycle per instruction.
- A reset at any point, including mid-instruction, immediately returns every output to its reset value. The control unit shares `reset`, so both blocks return to idle together.

## Test plan

- **Single instruction.** `start_addr=end_addr=3`, `mem[3]=0x1234`, control unit attached.
  - `imem_rd` is high at cycle 1 with address 3.
  - `instruction=0x1234` from cycle 3.
  - `en_i`, `en_s` and `en_c` are high at cycles 3, 4 and 5.
  - `finished` is high at cycle 8 and `instr_count=1`.
- **Straight-line program.** Addresses 0–3 hold four instructions.
  - `pc` steps 0, 1, 2, 3.
  - `finished` is high at cycle 29 and `instr_count=4`.
- **Stall.** Hold `stall` high for 3 cycles on entry to LOAD_EN.
  - `en_s` is delayed 3 cycles and `en_i`/`en_c` do not pulse in that window.
  - `finished` arrives 3 cycles later than the unstalled run.
- **Wrap-around.** `start_addr=0xFE`, `end_addr=0x01`.
  - Fetch addresses are 0xFE, 0xFF, 0x00, 0x01.
  - `instr_count=4`.
  - A `start` pulse mid-run is ignored and `pc` is unaffected.
- **Watchdog.** Tie `cu_done` low.
  - `error=1` and `busy=0` after 15 WAIT_DONE cycles.
  - A following `start` clears `error` and refetches from `start_addr`.
- **Reset mid-run.** Assert `reset` during WAIT_DONE of the second instruction.
  - All outputs are 0 in the same cycle.
  - After release, the sequencer stays in IDLE until `start`.
